// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int DATA_BITS_DEFAULT  = 8;
    localparam logic IDLE_LEVEL       = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// OVERSAMPLE-modulo sample counter; bit_done_o strobes for one clock on the last sample of a bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic bit_done_o
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bit_done_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter on the 16x sampling clock; define UART_TX_PARITY_EN to add an even-parity bit.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = DATA_BITS_DEFAULT,
    parameter int STOP_BITS  = 1
) (
    input  logic                 uart_sampling_clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 RsTx,
    output logic                 busy
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BCW-1:0]       bit_cnt_q;
    logic                 tx_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 bit_done;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk_i     (uart_sampling_clk),
        .rst_i     (reset),
        .en_i      (busy_q),
        .bit_done_o(bit_done)
    );

    // The line register follows the state one clock later, so every bit period
    // on RsTx is the corresponding state period delayed by a single clock.
    always_ff @(posedge uart_sampling_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= IDLE_LEVEL;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= IDLE_LEVEL;
                    if (valid && ready_q) begin
                        shift_q   <= tx_data;
                        bit_cnt_q <= '0;
                        state_q   <= START;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= ^tx_data;
`endif
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (bit_done) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    tx_q <= shift_q[0];
                    if (bit_done) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q   <= PARITY;
`else
                            state_q   <= STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_q <= parity_q;
                    if (bit_done) begin
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    tx_q <= IDLE_LEVEL;
                    if (bit_done) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            bit_cnt_q <= '0;
                            state_q   <= IDLE;
                            ready_q   <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q      <= IDLE_LEVEL;
                    bit_cnt_q <= '0;
                    state_q   <= IDLE;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign RsTx  = tx_q;

endmodule
